// File: rtl/uart_pkg.sv
// Shared definitions for the oversampled UART receiver.
//   - parity mode encodings used by the PARITY_BIT parameter
//   - receiver FSM state encoding
//   - parity_check helper: turns the XOR of data and parity bits into a pass flag
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } uart_state_t;

    // xor_all is the XOR of every data bit and the received parity bit.
    // Odd parity passes when that XOR is 1, even parity when it is 0.
    function automatic logic parity_check(input logic xor_all, input int mode);
        logic ok;
        if (mode == PARITY_ODD) begin
            ok = xor_all;
        end else begin
            ok = ~xor_all;
        end
        return ok;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter for the UART receiver.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   load_half      : load the start-bit (half period) delay
//   load_full      : load one full bit period
//   run            : enables tick generation while a frame is in progress
//   tick           : 1-cycle pulse marking the mid-bit sampling point
// The half load is OVERSAMPLE_FACTOR/2 - 2 because the start edge is only seen
// one cycle after the synchronizer output falls and the tick fires on the cycle
// after the counter reaches zero; together this lands the start-bit sample
// 2 + OVERSAMPLE_FACTOR/2 cycles after the raw line edge.
module uart_bit_timer #(
    parameter int OVERSAMPLE_FACTOR = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic load_half,
    input  logic load_full,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = $clog2(OVERSAMPLE_FACTOR);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(OVERSAMPLE_FACTOR / 2 - 2);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(OVERSAMPLE_FACTOR - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next counter value: loads win, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_half) begin
            cnt_d = HALF_LOAD;
        end else if (load_full) begin
            cnt_d = FULL_LOAD;
        end else if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Every tick in a running frame is followed by a reload or a return to
    // IDLE, so this is a single-cycle pulse.
    assign tick = run && (cnt_q == CNT_ZERO);

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   rx             : raw serial line (idles high, asynchronous)
//   flush          : clears converted and data_valid at the next edge
//   data           : last completed frame, bit 0 = first bit received
//   converted      : sticky "a frame completed" flag
//   data_valid     : sticky "last frame had good parity and stop bits"
//   busy           : high while a frame is being received
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int FRAME_BITS        = 8,
    parameter int PARITY_BIT        = 0,
    parameter int STOP_BITS         = 1,
    parameter int OVERSAMPLE_FACTOR = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  rx,
    input  logic                  flush,
    output logic [FRAME_BITS-1:0] data,
    output logic                  converted,
    output logic                  data_valid,
    output logic                  busy
);

    localparam bit PAR_EN = (PARITY_BIT == PARITY_ODD) || (PARITY_BIT == PARITY_EVEN);
    localparam int CNT_W  = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    logic                  rx_meta_q, rx_meta_d;
    logic                  rx_sync_q, rx_sync_d;
    logic                  armed_q, armed_d;
    uart_state_t           state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  par_ok_q, par_ok_d;
    logic                  stop_ok_q, stop_ok_d;
    logic [FRAME_BITS-1:0] data_q, data_d;
    logic                  converted_q, converted_d;
    logic                  data_valid_q, data_valid_d;
    logic                  busy_q, busy_d;

    logic load_half_s;
    logic load_full_s;
    logic run_s;
    logic tick_s;

    uart_bit_timer #(
        .OVERSAMPLE_FACTOR(OVERSAMPLE_FACTOR)
    ) u_bit_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .load_half(load_half_s),
        .load_full(load_full_s),
        .run      (run_s),
        .tick     (tick_s)
    );

    // Receiver FSM, shift register and sticky output flags.
    always_comb begin
        rx_meta_d    = rx;
        rx_sync_d    = rx_meta_q;
        // armed: the line has been seen high since the last start/framing error,
        // so a line stuck low after a bad stop bit cannot retrigger.
        armed_d      = rx_sync_q ? 1'b1 : armed_q;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_ok_d     = par_ok_q;
        stop_ok_d    = stop_ok_q;
        data_d       = data_q;
        busy_d       = busy_q;
        load_half_s  = 1'b0;
        load_full_s  = 1'b0;
        run_s        = (state_q != IDLE) && (state_q != DONE);

        // Flush first so a completing frame in the same cycle overrides it.
        if (flush) begin
            converted_d  = 1'b0;
            data_valid_d = 1'b0;
        end else begin
            converted_d  = converted_q;
            data_valid_d = data_valid_q;
        end

        case (state_q)
            IDLE: begin
                if (!rx_sync_q && armed_q) begin
                    state_d     = START;
                    load_half_s = 1'b1;
                    busy_d      = 1'b1;
                    armed_d     = 1'b0;
                    par_ok_d    = 1'b1;
                    stop_ok_d   = 1'b1;
                    bit_cnt_d   = CNT_ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_s && rx_sync_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (tick_s) begin
                    state_d     = DATA;
                    load_full_s = 1'b1;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    shift_d     = {rx_sync_q, shift_q[FRAME_BITS-1:1]};
                    load_full_s = 1'b1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = CNT_ZERO;
                        state_d   = PAR_EN ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (tick_s) begin
                    par_ok_d    = parity_check((^shift_q) ^ rx_sync_q, PARITY_BIT);
                    load_full_s = 1'b1;
                    state_d     = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (tick_s) begin
                    if (!rx_sync_q) begin
                        stop_ok_d = 1'b0;
                        armed_d   = 1'b0;
                    end else begin
                        stop_ok_d = stop_ok_q;
                    end
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d = DONE;
                    end else begin
                        bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                        load_full_s = 1'b1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            DONE: begin
                data_d       = shift_q;
                converted_d  = 1'b1;
                data_valid_d = par_ok_q && stop_ok_q;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // All state and output registers; reset abandons any frame in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            armed_q      <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= CNT_ZERO;
            shift_q      <= {FRAME_BITS{1'b0}};
            par_ok_q     <= 1'b1;
            stop_ok_q    <= 1'b1;
            data_q       <= {FRAME_BITS{1'b0}};
            converted_q  <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            armed_q      <= armed_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            stop_ok_q    <= stop_ok_d;
            data_q       <= data_d;
            converted_q  <= converted_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign data       = data_q;
    assign converted  = converted_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: 8 data bits, even parity,
// 1 stop bit, 15 clocks per bit. Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point.
module tb_uart_rx_oversampled;

    localparam int FB = 8;
    localparam int PB = 2;
    localparam int SB = 1;
    localparam int OF = 15;
    // Last stop sample at 2 + 7 + 10*15 = 159 edges after the start edge;
    // converted is first seen high after edge 160.
    localparam int EXP_CONV_EDGE = 160;
    // busy rises at edge 3, falls at edge 160 -> high after edges 3..159.
    localparam int EXP_BUSY_CNT  = 157;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          rx    = 1'b1;
    logic          flush = 1'b0;
    logic [FB-1:0] data;
    logic          converted;
    logic          data_valid;
    logic          busy;

    int tests_run    = 0;
    int tests_failed = 0;

    int busy_cnt;
    int conv_low;
    int conv_edge;

    uart_rx_oversampled #(
        .FRAME_BITS       (FB),
        .PARITY_BIT       (PB),
        .STOP_BITS        (SB),
        .OVERSAMPLE_FACTOR(OF)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .rx        (rx),
        .flush     (flush),
        .data      (data),
        .converted (converted),
        .data_valid(data_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sends start, 8 data bits LSB first, parity bit, stop bit (11 bit times).
    // Counts cycles with busy high / converted low and the first edge with
    // converted high (0 if never).
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              output int b_cnt, output int c_low, output int c_edge);
        logic [10:0] bits;
        int          e;
        bits   = {stop, par, d, 1'b0};
        b_cnt  = 0;
        c_low  = 0;
        c_edge = 0;
        e      = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            repeat (OF) begin
                @(posedge clk);
                #1;
                e++;
                if (busy) b_cnt++;
                if (!converted) c_low++;
                if (converted && (c_edge == 0)) c_edge = e;
            end
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data", 32'(data), 32'h0);
        check_eq("rst_converted", 32'(converted), 32'h0);
        check_eq("rst_data_valid", 32'(data_valid), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        idle(5);

        // Valid frame with latency and busy window
        send_frame(8'hA5, 1'b0, 1'b1, busy_cnt, conv_low, conv_edge);
        check_eq("t1_busy_cycles", 32'(busy_cnt), 32'(EXP_BUSY_CNT));
        check_eq("t1_conv_latency", 32'(conv_edge), 32'(EXP_CONV_EDGE));
        check_eq("t1_data", 32'(data), 32'hA5);
        check_eq("t1_valid", 32'(data_valid), 32'h1);
        check_eq("t1_busy_after", 32'(busy), 32'h0);
        pulse_flush();

        // Bad parity
        send_frame(8'h3C, 1'b1, 1'b1, busy_cnt, conv_low, conv_edge);
        check_eq("t2_converted", 32'(converted), 32'h1);
        check_eq("t2_data", 32'(data), 32'h3C);
        check_eq("t2_valid", 32'(data_valid), 32'h0);
        pulse_flush();

        // Framing error, line held low, then recovery
        send_frame(8'h81, 1'b0, 1'b0, busy_cnt, conv_low, conv_edge);
        repeat (20) @(posedge clk);
        #1;
        check_eq("t3_converted", 32'(converted), 32'h1);
        check_eq("t3_valid", 32'(data_valid), 32'h0);
        check_eq("t3_data", 32'(data), 32'h81);
        check_eq("t3_no_retrigger", 32'(busy), 32'h0);
        idle(5);
        pulse_flush();
        send_frame(8'h55, 1'b0, 1'b1, busy_cnt, conv_low, conv_edge);
        check_eq("t3_rec_data", 32'(data), 32'h55);
        check_eq("t3_rec_valid", 32'(data_valid), 32'h1);
        check_eq("t3_rec_converted", 32'(converted), 32'h1);
        pulse_flush();
        idle(3);

        // False start: 3-cycle glitch
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        check_eq("t4_busy_pulse", 32'(busy), 32'h1);
        idle(10);
        check_eq("t4_busy_cleared", 32'(busy), 32'h0);
        check_eq("t4_no_convert", 32'(converted), 32'h0);
        send_frame(8'h12, 1'b0, 1'b1, busy_cnt, conv_low, conv_edge);
        check_eq("t4_data", 32'(data), 32'h12);
        check_eq("t4_valid", 32'(data_valid), 32'h1);

        // Flush handshake and back-to-back frames
        pulse_flush();
        send_frame(8'hF0, 1'b0, 1'b1, busy_cnt, conv_low, conv_edge);
        check_eq("t5_f0_converted", 32'(converted), 32'h1);
        pulse_flush();
        check_eq("t5_flush_converted", 32'(converted), 32'h0);
        check_eq("t5_flush_valid", 32'(data_valid), 32'h0);
        check_eq("t5_flush_data_kept", 32'(data), 32'hF0);
        send_frame(8'h0F, 1'b0, 1'b1, busy_cnt, conv_low, conv_edge);
        check_eq("t5_0f_converted", 32'(converted), 32'h1);
        check_eq("t5_0f_data", 32'(data), 32'h0F);
        send_frame(8'h77, 1'b0, 1'b1, busy_cnt, conv_low, conv_edge);
        check_eq("t5_77_data", 32'(data), 32'h77);
        send_frame(8'h88, 1'b0, 1'b1, busy_cnt, conv_low, conv_edge);
        check_eq("t5_conv_held", 32'(conv_low), 32'h0);
        check_eq("t5_88_data", 32'(data), 32'h88);
        check_eq("t5_88_converted", 32'(converted), 32'h1);

        // Reset during data bit 4
        pat = 8'hFF;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (OF) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 rx = pat[i];
            repeat (OF) @(posedge clk);
        end
        #1 rx = pat[4];
        repeat (7) @(posedge clk);
        #2;
        check_eq("t6_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_data", 32'(data), 32'h0);
        check_eq("t6_rst_converted", 32'(converted), 32'h0);
        check_eq("t6_rst_valid", 32'(data_valid), 32'h0);
        check_eq("t6_rst_busy", 32'(busy), 32'h0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);
        send_frame(8'hC3, 1'b0, 1'b1, busy_cnt, conv_low, conv_edge);
        check_eq("t6_data", 32'(data), 32'hC3);
        check_eq("t6_valid", 32'(data_valid), 32'h1);
        check_eq("t6_converted", 32'(converted), 32'h1);
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
